// File: rtl/decomp_completion_ctrl.sv
// rtl/decomp_completion_ctrl.sv - page/block completion controller for the snappy decompressor
module decomp_completion_ctrl #(
    parameter int NUM_PARSER   = 6,
    parameter int NUM_RAM      = 16,
    parameter int QUIET_CYCLES = 16,
    parameter int TIMEOUT_W    = 20,
    parameter int BLK_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  tf_empty,
    input  logic [NUM_PARSER-1:0] ps_empty,
    input  logic [NUM_RAM-1:0]    ram_empty,
    input  logic                  block_input_finish,
    input  logic                  page_input_finish,
    input  logic                  cl_finish,
    output logic                  block_finish,
    output logic                  page_finish,
    output logic                  page_done,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [BLK_W-1:0]      blocks_done,
    output logic [2:0]            state_o
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        CLEAN = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t               state_q;
    logic                 all_empty_q;
    logic [QW-1:0]        quiet_cnt_q, quiet_cnt_d;
    logic                 quiet;
    logic                 in_done_q, in_done_d;
    logic                 blk_pend_q, blk_pend_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_inc;
    logic                 wd_expire;
    logic                 pif_set, bif_set, run_go, blk_drain;
    logic                 block_finish_q, page_finish_q, page_done_q, busy_q, timeout_err_q;
    logic [BLK_W-1:0]     blocks_done_q;

    // Register the combined emptiness and count consecutive all-empty cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            all_empty_q <= 1'b0;
            quiet_cnt_q <= '0;
        end else begin
            all_empty_q <= tf_empty & (&ps_empty) & (&ram_empty);
            quiet_cnt_q <= quiet_cnt_d;
        end
    end

    // Saturating quiet counter next state; any non-empty cycle restarts it
    always_comb begin
        quiet_cnt_d = quiet_cnt_q;
        if (!all_empty_q) begin
            quiet_cnt_d = '0;
        end else if (quiet_cnt_q != QW'(QUIET_CYCLES)) begin
            quiet_cnt_d = quiet_cnt_q + QW'(1);
        end
    end

    assign quiet = (quiet_cnt_q == QW'(QUIET_CYCLES));

    // Flag next state, block-drain condition and watchdog increment
    always_comb begin
        pif_set    = busy_q & page_input_finish;
        bif_set    = busy_q & block_input_finish;
        blk_drain  = ((state_q == RUN) || (state_q == DRAIN)) && blk_pend_q && quiet;
        in_done_d  = in_done_q | pif_set;
        // a fresh block_input_finish wins over the drain clear
        blk_pend_d = bif_set | (blk_pend_q & ~blk_drain);
        run_go     = (in_done_q | pif_set) & tf_empty;
        wd_inc     = wd_q + TIMEOUT_W'(1);
        wd_expire  = (wd_inc == '1);
    end

    // Page FSM with registered outputs; abort overrides every other transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            in_done_q      <= 1'b0;
            blk_pend_q     <= 1'b0;
            wd_q           <= '0;
            block_finish_q <= 1'b0;
            page_finish_q  <= 1'b0;
            page_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            blocks_done_q  <= '0;
        end else begin
            in_done_q      <= in_done_d;
            blk_pend_q     <= blk_pend_d;
            block_finish_q <= blk_drain;
            page_done_q    <= 1'b0;
            if (blk_drain) begin
                blocks_done_q <= blocks_done_q + BLK_W'(1);
            end
            case (state_q)
                IDLE, ERR: begin
                    if (start) begin
                        state_q       <= RUN;
                        busy_q        <= 1'b1;
                        in_done_q     <= 1'b0;
                        blk_pend_q    <= 1'b0;
                        blocks_done_q <= '0;
                        timeout_err_q <= 1'b0;
                        wd_q          <= '0;
                    end
                end
                RUN: begin
                    if (run_go) begin
                        state_q <= DRAIN;
                        wd_q    <= '0;
                    end
                end
                DRAIN: begin
                    if (quiet) begin
                        state_q       <= CLEAN;
                        page_finish_q <= 1'b1;
                        wd_q          <= '0;
                    end else if (wd_expire) begin
                        state_q       <= ERR;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        page_finish_q <= 1'b0;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                CLEAN: begin
                    if (cl_finish) begin
                        state_q     <= DONE;
                        page_done_q <= 1'b1;
                    end else if (wd_expire) begin
                        state_q       <= ERR;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        page_finish_q <= 1'b0;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    page_finish_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (abort && (state_q != IDLE)) begin
                state_q        <= IDLE;
                busy_q         <= 1'b0;
                block_finish_q <= 1'b0;
                page_done_q    <= 1'b0;
                page_finish_q  <= 1'b0;
                in_done_q      <= 1'b0;
                blk_pend_q     <= 1'b0;
                wd_q           <= '0;
                blocks_done_q  <= blocks_done_q;
            end
        end
    end

    assign block_finish = block_finish_q;
    assign page_finish  = page_finish_q;
    assign page_done    = page_done_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign blocks_done  = blocks_done_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_decomp_completion_ctrl.sv
// tb/tb_decomp_completion_ctrl.sv - self-checking bench for decomp_completion_ctrl
module tb_decomp_completion_ctrl;
    localparam int Q      = 16;
    localparam int WD_LIM = (1 << 20) - 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_CLEAN = 3, S_DONE = 4, S_ERR = 5;

    logic        clk = 1'b0;
    logic        rst, start, abort, tf_empty;
    logic [5:0]  ps_empty;
    logic [15:0] ram_empty;
    logic        block_input_finish, page_input_finish, cl_finish;

    logic        block_finish, page_finish, page_done, busy, timeout_err;
    logic [15:0] blocks_done;
    logic [2:0]  state_o;

    logic        t_block_finish, t_page_finish, t_page_done, t_busy, t_timeout_err;
    logic [15:0] t_blocks_done;
    logic [2:0]  t_state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decomp_completion_ctrl #(.NUM_PARSER(6), .NUM_RAM(16), .QUIET_CYCLES(Q), .TIMEOUT_W(20), .BLK_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tf_empty(tf_empty),
        .ps_empty(ps_empty), .ram_empty(ram_empty),
        .block_input_finish(block_input_finish), .page_input_finish(page_input_finish),
        .cl_finish(cl_finish), .block_finish(block_finish), .page_finish(page_finish),
        .page_done(page_done), .busy(busy), .timeout_err(timeout_err),
        .blocks_done(blocks_done), .state_o(state_o)
    );

    decomp_completion_ctrl #(.NUM_PARSER(6), .NUM_RAM(16), .QUIET_CYCLES(Q), .TIMEOUT_W(4), .BLK_W(16)) u_dut_t (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tf_empty(tf_empty),
        .ps_empty(ps_empty), .ram_empty(ram_empty),
        .block_input_finish(block_input_finish), .page_input_finish(page_input_finish),
        .cl_finish(cl_finish), .block_finish(t_block_finish), .page_finish(t_page_finish),
        .page_done(t_page_done), .busy(t_busy), .timeout_err(t_timeout_err),
        .blocks_done(t_blocks_done), .state_o(t_state_o)
    );

    typedef struct {
        logic       st, ab, pif, bif, clf, tf, emp;
        int         reps;
        logic [2:0] e_state;
        logic       e_pf, e_bf, e_pd, e_busy;
        int         e_blk;
    } vec_t;

    vec_t tbl[$];

    // behavioural reference state
    int   m_state, m_blocks, m_wd;
    bit   m_in_done, m_blk_pend, m_pf, m_bf, m_pd, m_te;
    bit   m_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_empty(input logic e);
        ps_empty  = {6{e}};
        ram_empty = {16{e}};
    endtask

    task automatic add(input logic st, ab, pif, bif, clf, tf, emp, input int reps,
                       input logic [2:0] es, input logic epf, ebf, epd, ebusy, input int eblk);
        vec_t v;
        v.st = st; v.ab = ab; v.pif = pif; v.bif = bif; v.clf = clf; v.tf = tf; v.emp = emp;
        v.reps = reps; v.e_state = es; v.e_pf = epf; v.e_bf = ebf; v.e_pd = epd;
        v.e_busy = ebusy; v.e_blk = eblk;
        tbl.push_back(v);
    endtask

    // quiescent in cycle n iff the raw all-empty condition held in cycles n-2 .. n-1-Q
    function automatic bit m_quiet();
        if (m_hist.size() < Q + 1) return 1'b0;
        for (int i = 1; i <= Q; i++) begin
            if (!m_hist[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // advance the reference by one clock, using the inputs currently driven
    task automatic model_step();
        bit raw, quiet, is_busy, drain, page_in;
        raw = tf_empty & (&ps_empty) & (&ram_empty);
        if (rst) begin
            m_state = S_IDLE; m_in_done = 0; m_blk_pend = 0; m_pf = 0; m_bf = 0;
            m_pd = 0; m_te = 0; m_blocks = 0; m_wd = 0;
            m_hist.delete();
            m_hist.push_front(1'b0);
            return;
        end
        quiet   = m_quiet();
        is_busy = m_state inside {S_RUN, S_DRAIN, S_CLEAN, S_DONE};
        drain   = (m_state == S_RUN || m_state == S_DRAIN) && m_blk_pend && quiet;
        page_in = m_in_done || (is_busy && page_input_finish);
        m_bf = drain;
        m_pd = 0;
        if (is_busy && page_input_finish) m_in_done = 1;
        m_blk_pend = (is_busy && block_input_finish) || (m_blk_pend && !drain);
        if (abort && m_state != S_IDLE) begin
            m_state = S_IDLE; m_bf = 0; m_pd = 0; m_pf = 0;
            m_in_done = 0; m_blk_pend = 0; m_wd = 0;
        end else begin
            if (drain) m_blocks = (m_blocks + 1) % 65536;
            case (m_state)
                S_IDLE, S_ERR: if (start) begin
                    m_state = S_RUN; m_in_done = 0; m_blk_pend = 0;
                    m_blocks = 0; m_te = 0; m_wd = 0;
                end
                S_RUN: if (page_in && tf_empty) begin
                    m_state = S_DRAIN; m_wd = 0;
                end
                S_DRAIN: begin
                    if (quiet) begin m_state = S_CLEAN; m_pf = 1; m_wd = 0; end
                    else if (m_wd + 1 == WD_LIM) begin m_state = S_ERR; m_te = 1; m_pf = 0; end
                    else m_wd++;
                end
                S_CLEAN: begin
                    if (cl_finish) begin m_state = S_DONE; m_pd = 1; end
                    else if (m_wd + 1 == WD_LIM) begin m_state = S_ERR; m_te = 1; m_pf = 0; end
                    else m_wd++;
                end
                S_DONE: begin m_state = S_IDLE; m_pf = 0; end
                default: m_state = S_IDLE;
            endcase
        end
        m_hist.push_front(raw);
        if (m_hist.size() > Q + 1) void'(m_hist.pop_back());
    endtask

    initial begin
        int n;
        bit mode_q;
        int mode_left;
        logic [31:0] exp_v;

        rst = 1; start = 0; abort = 0; tf_empty = 0; set_empty(1'b0);
        block_input_finish = 0; page_input_finish = 0; cl_finish = 0;
        cycn(2);
        chk("reset_state", {state_o, page_finish, block_finish, page_done, busy, timeout_err, blocks_done}, 32'h0);
        rst = 0;

        // st ab pif bif clf tf emp reps | state pf bf pd busy blk
        add(0,0,0,0,0,0,0, 1,  0,0,0,0,0,0);
        add(1,0,0,0,0,0,0, 1,  1,0,0,0,1,0);
        add(0,0,1,0,0,0,0, 1,  1,0,0,0,1,0);
        add(0,0,0,0,0,1,0, 1,  2,0,0,0,1,0);
        add(0,0,0,0,0,1,1, 17, 2,0,0,0,1,0);
        add(0,0,0,0,0,1,1, 1,  3,1,0,0,1,0);
        add(0,0,0,0,1,1,1, 1,  4,1,0,1,1,0);
        add(0,0,0,0,0,1,1, 1,  0,0,0,0,0,0);
        add(1,0,0,0,0,1,1, 1,  1,0,0,0,1,0);
        add(0,0,1,0,0,1,1, 1,  2,0,0,0,1,0);
        add(0,0,0,0,0,1,1, 1,  3,1,0,0,1,0);
        add(0,1,0,0,1,1,1, 1,  0,0,0,0,0,0);
        add(0,0,0,0,0,1,1, 1,  0,0,0,0,0,0);
        add(1,0,0,0,0,1,0, 1,  1,0,0,0,1,0);
        add(0,0,0,1,0,1,0, 1,  1,0,0,0,1,0);
        add(0,0,0,0,0,1,1, 17, 1,0,0,0,1,0);
        add(0,0,0,0,0,1,1, 1,  1,0,1,0,1,1);
        add(0,0,0,0,0,1,1, 1,  1,0,0,0,1,1);
        add(0,0,0,1,0,1,1, 1,  1,0,0,0,1,1);
        add(0,0,0,0,0,1,1, 1,  1,0,1,0,1,2);
        add(1,0,0,0,0,1,1, 1,  1,0,0,0,1,2);
        add(0,0,0,0,0,1,0, 2,  1,0,0,0,1,2);
        add(0,0,0,1,0,1,0, 1,  1,0,0,0,1,2);
        add(0,0,0,0,0,1,1, 17, 1,0,0,0,1,2);
        add(0,0,0,0,0,1,1, 1,  1,0,1,0,1,3);
        add(0,1,0,0,0,1,1, 1,  0,0,0,0,0,3);

        foreach (tbl[i]) begin
            start = tbl[i].st; abort = tbl[i].ab; page_input_finish = tbl[i].pif;
            block_input_finish = tbl[i].bif; cl_finish = tbl[i].clf;
            tf_empty = tbl[i].tf; set_empty(tbl[i].emp);
            cycn(tbl[i].reps);
            chk($sformatf("vec%0d", i),
                {8'h0, state_o, page_finish, block_finish, page_done, busy, blocks_done},
                {8'h0, tbl[i].e_state, tbl[i].e_pf, tbl[i].e_bf, tbl[i].e_pd, tbl[i].e_busy, 16'(tbl[i].e_blk)});
        end
        start = 0; abort = 0; page_input_finish = 0; block_input_finish = 0; cl_finish = 0;

        // one-cycle glitch on a parser lane during the quiet count
        tf_empty = 1; set_empty(1'b0);
        start = 1; cyc(); start = 0;
        page_input_finish = 1; cyc(); page_input_finish = 0;
        set_empty(1'b1);
        cycn(10);
        ps_empty[3] = 1'b0; cyc(); ps_empty[3] = 1'b1;
        n = 11;
        while (!page_finish && n < 60) begin cyc(); n++; end
        chk("glitch_pf_cycle", n, 29);
        chk("glitch_state", state_o, S_CLEAN);
        abort = 1; cyc(); abort = 0;

        // synchronous reset while draining
        cycn(20);
        start = 1; cyc(); start = 0;
        block_input_finish = 1; cyc(); block_input_finish = 0;
        cyc();
        chk("rst_pre_blk", {block_finish, blocks_done}, {1'b1, 16'd1});
        ps_empty = '0; cycn(3);
        page_input_finish = 1; cyc(); page_input_finish = 0;
        chk("rst_pre_state", state_o, S_DRAIN);
        rst = 1; cyc(); rst = 0;
        chk("rst_mid_page", {state_o, page_finish, block_finish, page_done, busy, timeout_err, blocks_done}, 32'h0);

        // watchdog expiry on the 4-bit instance
        tf_empty = 1; ps_empty = '1; ram_empty = 16'hFFFE;
        start = 1; cyc(); start = 0;
        page_input_finish = 1; cyc(); page_input_finish = 0;
        chk("to_drain", t_state_o, S_DRAIN);
        n = 0;
        while (t_state_o != 3'(S_ERR) && n < 40) begin cyc(); n++; end
        chk("to_cycles", n, 15);
        chk("to_flags", {t_timeout_err, t_busy, t_page_finish}, 3'b100);
        start = 1; cyc(); start = 0;
        chk("to_restart", {t_state_o, t_timeout_err, t_busy}, {3'(S_RUN), 1'b0, 1'b1});
        abort = 1; cyc(); abort = 0;

        // randomized traffic against the reference
        rst = 1; model_step(); cyc(); rst = 0;
        mode_q = 0; mode_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (mode_left == 0) begin
                mode_q    = ($urandom_range(0, 3) != 0);
                mode_left = $urandom_range(5, 40);
            end
            mode_left--;
            rst                = ($urandom_range(0, 499) == 0);
            start              = ($urandom_range(0, 19) == 0);
            abort              = ($urandom_range(0, 79) == 0);
            page_input_finish  = ($urandom_range(0, 14) == 0);
            block_input_finish = ($urandom_range(0, 9) == 0);
            cl_finish          = ($urandom_range(0, 7) == 0);
            tf_empty           = mode_q ? 1'b1 : 1'($urandom_range(0, 1));
            ps_empty           = mode_q ? 6'h3F : 6'($urandom);
            ram_empty          = mode_q ? 16'hFFFF : 16'($urandom);
            if (mode_q && $urandom_range(0, 59) == 0) ps_empty[$urandom_range(0, 5)] = 1'b0;
            model_step();
            cyc();
            exp_v = {7'h0, 3'(m_state), m_pf, m_bf, m_pd,
                     1'(m_state inside {S_RUN, S_DRAIN, S_CLEAN, S_DONE}), m_te, 16'(m_blocks)};
            chk($sformatf("rand%0d", c),
                {7'h0, state_o, page_finish, block_finish, page_done, busy, timeout_err, blocks_done}, exp_v);
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decomp_completion_ctrl.md
# decomp_completion_ctrl

Parametrised completion controller for the snappy decompressor datapath. It tracks a page (one file) from `start` to final BRAM clean-out. It detects pipeline quiescence across the token FIFO, N parsers and M history RAM banks, and emits a per-64KB-block `block_finish` pulse and a page-level `page_finish` level. A drain timeout, an abort path and a block counter are added for host visibility. It sits beside the preparser/parser array and hands off to the clean/output stage.

## Interface
- `NUM_PARSER`, 6, number of parser lanes (1..32)
- `NUM_RAM`, 16, number of history RAM banks (1..64)
- `QUIET_CYCLES`, 16, consecutive all-empty cycles required before declaring quiescence (1..255)
- `TIMEOUT_W`, 20, width of the drain/clean watchdog counter (4..32)
- `BLK_W`, 16, width of the completed-block counter

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse, begin a new page
- `abort` in 1: one-cycle pulse, abandon the current page
- `tf_empty` in 1: token FIFO empty
- `ps_empty` in NUM_PARSER: per-parser empty
- `ram_empty` in NUM_RAM: per-bank empty
- `block_input_finish` in 1: pulse, last token of current 64KB block preparsed
- `page_input_finish` in 1: pulse, last token of the page preparsed
- `cl_finish` in 1: pulse, BRAM valid bits cleaned
- `block_finish` out 1: one-cycle pulse per drained block
- `page_finish` out 1: level, page fully decompressed into BRAMs
- `page_done` out 1: one-cycle pulse, page retired after clean
- `busy` out 1: high in any state except IDLE/ERR
- `timeout_err` out 1: sticky, watchdog expired
- `blocks_done` out BLK_W: blocks completed this page
- `state_o` out 3: current state encoding (debug)

## Operation
- `all_empty_r` is registered each cycle as `tf_empty & (&ps_empty) & (&ram_empty)`.
- `quiet_cnt`, width `$clog2(QUIET_CYCLES+1)`: cleared when `all_empty_r`=0, else saturating increment to `QUIET_CYCLES`. `quiet` = (`quiet_cnt`==`QUIET_CYCLES`).
- Flags `in_done` and `blk_pend` are set by `page_input_finish` / `block_input_finish` only when `busy`. Both are cleared on `start`.
- States (encoding): IDLE=0, RUN=1, DRAIN=2, CLEAN=3, DONE=4, ERR=5.
- IDLE: `start` → RUN. On the same edge, clear `in_done`, `blk_pend`, `blocks_done`, `timeout_err` and the watchdog.
- RUN: `in_done` & `tf_empty` → DRAIN. A `page_input_finish` arriving this cycle counts, giving a same-cycle transition if `tf_empty`.
- DRAIN: `quiet` → CLEAN, and `page_finish` is set on that edge.
- CLEAN: hold `page_finish`=1. `cl_finish` → DONE.
- DONE: `page_finish`←0, `page_done`=1 for this cycle only, → IDLE.
- ERR: `timeout_err`=1 held; `page_finish`=0. `start` → RUN, with the same clears as in IDLE.
- Block drain (RUN or DRAIN): `blk_pend` & `quiet` → `block_finish` pulse, clear `blk_pend`, `blocks_done`+1 (wraps mod 2^BLK_W). If a new `block_input_finish` arrives in the same cycle, `blk_pend` stays set; set has priority over clear.
- Watchdog: cleared on entry to DRAIN and on entry to CLEAN; increments in those states. If it reaches all-ones → ERR.
- `abort` in any non-IDLE state → IDLE next edge. All pulses, `page_finish`, flags and the watchdog are cleared; `blocks_done` is retained. `abort` has priority over every other transition.
- `start` outside IDLE/ERR is ignored.

## Timing
- Reset values: state IDLE; `block_finish`, `page_finish`, `page_done`, `busy`, `timeout_err`=0; `blocks_done`=0; `quiet_cnt`=0.
- All outputs are registered; no combinational input→output path.
- All empty inputs first high in cycle t and held → `all_empty_r` high from t+1 → `quiet_cnt`==Q after edge t+1+Q → `page_finish`/`block_finish` asserted from edge t+2+Q (Q+2 cycle latency).
- A single-cycle deassertion of any empty input restarts the count.
- `cl_finish` in cycle c (state CLEAN) → `page_done` high in cycle c+1, `page_finish` low from c+2, IDLE at c+2.
- `cl_finish` outside CLEAN is ignored.
- `rst` mid-page: state IDLE next edge, identical to power-on reset.

## Test plan
- Nominal, Q=16: `start`; `page_input_finish` with `tf_empty`=1; all empties high at cycle t → `page_finish` rises at t+18. `cl_finish` → `page_done` 1 cycle, then IDLE.
- Glitch: one-cycle `ps_empty[3]`=0 at count 10 → counter restarts; `page_finish` delayed by 11 cycles relative to the nominal case.
- Blocks: 3 `block_input_finish` pulses, each followed by quiescence → 3 `block_finish` pulses, `blocks_done`=3, `page_finish` still 0 until `page_input_finish`.
- Timeout, TIMEOUT_W=4: enter DRAIN with `ram_empty[0]` stuck 0 → ERR after 15 cycles, `timeout_err`=1, `busy`=0. `start` clears `timeout_err`.
- Abort in CLEAN → `page_finish` 0 next edge, IDLE, no `page_done`. Abort simultaneous with `cl_finish` → abort wins.
- Reset with `rst`=1 during DRAIN → all outputs at reset values next cycle.
